pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries a packed payload with a valid bit, inserts a NOP bubble on a pipeline stall
//  boundary, holds on downstream stall, clears on flush, and returns a loop-back field
//  to the upstream stage (delay-slot style). Driven by the central 6-bit stall controller.
// PARAMETERS
//  DATA_W     32       payload width (aluop|alusel|reg1|reg2|wd|wreg|... packed by caller)
//  FB_W       1        loop-back field width, returned to the upstream stage
//  STALL_W    6        stall vector width; must be >= STAGE_IDX+2
//  STAGE_IDX  2        stall bit of the upstream stage; STAGE_IDX+1 is this stage's consumer
//  NOP_VALUE  {DATA_W{1'b0}}  payload loaded on reset, bubble and flush
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous reset, active-low (0 = reset)
//  stall      in   STALL_W  per-stage stop vector, 1 = Stop
//  flush      in   1        exception/redirect flush, 1 = clear this stage
//  in_valid   in   1        upstream entry valid
//  in_data    in   DATA_W   upstream payload
//  in_fb      in   FB_W     loop-back value to capture (e.g. next_inst_in_delayslot)
//  out_valid  out  1        registered valid
//  out_data   out  DATA_W   registered payload
//  out_fb     out  FB_W     registered loop-back value to upstream
//  bubble_o   out  1        1 for the cycle after a bubble was inserted
// BEHAVIOUR
//  - Reset (rst=0, async, immediate): out_valid=0, out_data=NOP_VALUE, out_fb=0, bubble_o=0.
//  - Per posedge, priority order:
//    1 flush=1                          -> out_valid=0, out_data=NOP_VALUE, out_fb=0, bubble_o=0
//    2 up=Stop & down=NoStop            -> BUBBLE: out_valid=0, out_data=NOP_VALUE,
//                                          out_fb held, bubble_o=1
//    3 up=NoStop                        -> LOAD: out_valid=in_valid, out_data=in_data,
//                                          out_fb=in_fb, bubble_o=0
//    4 up=Stop & down=Stop              -> HOLD: all outputs unchanged (bubble_o too)
//    where up=stall[STAGE_IDX], down=stall[STAGE_IDX+1].
//  - Latency 1 cycle in LOAD; no combinational path from inputs to outputs.
//  - up=NoStop & down=Stop is a controller error: treated as LOAD (no data loss upstream
//    is guaranteed by controller); assertion flags it in simulation.
//  - in_valid=0 on LOAD: out_data still loads in_data (caller presents NOP).
//  - Flush during HOLD wins: stage cleared, next cycle resumes per stall.
//  - Reset deasserting mid-stall: first edge evaluates normally from reset state.
//  - Whole payload updated on every branch; no partial-field updates.
// CONFIGURATION
//  PIPE_STALL_CNT_EN defined: adds outputs hold_cnt[15:0] and bubble_cnt[15:0];
//    hold_cnt +1 per HOLD edge, bubble_cnt +1 per BUBBLE edge, both saturate at 16'hFFFF,
//    cleared by reset only (not by flush). Undefined: ports and logic absent.
// STRUCTURE
//  - Shared defines package: Stop/NoStop, RstEnable(=1'b0), stall bit indices
//    (STALL_PC..STALL_WB), NOP payload constants per stage, STALL_W.
//  - Optional sub-module sat_counter (WIDTH=16) instantiated twice under PIPE_STALL_CNT_EN.
//  - Payload pack/unpack done by stage wrappers, not here.
// TESTING
//  - Reset: rst=0 mid-cycle with in_data=32'hDEADBEEF -> outputs NOP/0 immediately, async.
//  - LOAD: stall=6'b000000, in_data=32'h12345678,in_valid=1,in_fb=1 -> next edge
//    out_data=32'h12345678,out_valid=1,out_fb=1.
//  - BUBBLE: stall=6'b000111 (STAGE_IDX=2) -> out_valid=0,out_data=NOP,bubble_o=1,out_fb held.
//  - HOLD: stall=6'b001111 for 3 edges -> outputs frozen; with PIPE_STALL_CNT_EN hold_cnt=3.
//  - Flush priority: flush=1 with stall=6'b001111 -> out_valid=0,out_data=NOP,out_fb=0.
//  - Saturation: force 70000 HOLD edges -> hold_cnt=16'hFFFF, no wrap.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline defines: stall polarity, reset level, stall bit indices, NOP payloads,
// and the per-edge action decode used by pipe_stage_reg.
package pipe_stage_reg_pkg;

    localparam int unsigned STALL_W = 6;

    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;
    localparam logic RstEnable = 1'b0;

    localparam int unsigned STALL_PC  = 0;
    localparam int unsigned STALL_IF  = 1;
    localparam int unsigned STALL_ID  = 2;
    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;
    localparam int unsigned STALL_WB  = 5;

    localparam logic [31:0] NOP_IF_ID  = 32'h0000_0000;
    localparam logic [31:0] NOP_ID_EX  = 32'h0000_0000;
    localparam logic [31:0] NOP_EX_MEM = 32'h0000_0000;
    localparam logic [31:0] NOP_MEM_WB = 32'h0000_0000;

    typedef enum logic [1:0] {
        ActLoad,
        ActBubble,
        ActHold,
        ActFlush
    } stage_act_e;

    // Flush beats everything; up=NoStop always loads, even if down is (illegally) stopped.
    function automatic stage_act_e stage_act(input logic flush, input logic up,
                                             input logic down);
        stage_act_e act;
        if (flush) begin
            act = ActFlush;
        end else if (up == Stop && down == NoStop) begin
            act = ActBubble;
        end else if (up == NoStop) begin
            act = ActLoad;
        end else begin
            act = ActHold;
        end
        return act;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the optional stall statistics of pipe_stage_reg.
module pipe_stage_reg_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with bubble/hold/flush and a loop-back field.
// Optional PIPE_STALL_CNT_EN adds saturating hold_cnt/bubble_cnt statistics outputs.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       FB_W      = 1,
    parameter int unsigned       STALL_W   = pipe_stage_reg_pkg::STALL_W,
    parameter int unsigned       STAGE_IDX = 2,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [FB_W-1:0]    in_fb,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [FB_W-1:0]    out_fb,
    output logic               bubble_o
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [15:0]        hold_cnt,
    output logic [15:0]        bubble_cnt
`endif
);

    import pipe_stage_reg_pkg::*;

    if (STALL_W < STAGE_IDX + 2) begin : g_bad_cfg
        $error("pipe_stage_reg: STALL_W must be >= STAGE_IDX+2");
    end

    logic       up;
    logic       down;
    stage_act_e act;
    logic       unused_stall;

    assign up           = stall[STAGE_IDX];
    assign down         = stall[STAGE_IDX+1];
    assign act          = stage_act(flush, up, down);
    assign unused_stall = ^stall;

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [FB_W-1:0]   fb_q;
    logic              bubble_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            valid_q  <= 1'b0;
            data_q   <= NOP_VALUE;
            fb_q     <= '0;
            bubble_q <= 1'b0;
        end else begin
            unique case (act)
                ActFlush: begin
                    valid_q  <= 1'b0;
                    data_q   <= NOP_VALUE;
                    fb_q     <= '0;
                    bubble_q <= 1'b0;
                end
                // Loop-back field is held: upstream is stopped and still owns it.
                ActBubble: begin
                    valid_q  <= 1'b0;
                    data_q   <= NOP_VALUE;
                    bubble_q <= 1'b1;
                end
                ActLoad: begin
                    valid_q  <= in_valid;
                    data_q   <= in_data;
                    fb_q     <= in_fb;
                    bubble_q <= 1'b0;
                end
                ActHold: begin
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_fb    = fb_q;
    assign bubble_o  = bubble_q;

`ifdef PIPE_STALL_CNT_EN
    logic hold_inc;
    logic bubble_inc;

    assign hold_inc   = (act == ActHold);
    assign bubble_inc = (act == ActBubble);

    pipe_stage_reg_sat_counter #(
        .WIDTH (16)
    ) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hold_inc),
        .count (hold_cnt)
    );

    pipe_stage_reg_sat_counter #(
        .WIDTH (16)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );
`else
    // Statistics counters are not built in this configuration.
`endif

    // The stall controller must never let a stage run while its consumer is stopped.
    ap_stall_order: assert property (@(posedge clk) disable iff (rst == RstEnable)
        !(up == NoStop && down == Stop));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized self-checking bench for pipe_stage_reg against a rule-level reference model.
// Define PIPE_STALL_CNT_EN to also check hold_cnt/bubble_cnt and their saturation.
module tb_pipe_stage_reg;

    localparam int unsigned DW  = 32;
    localparam int unsigned FBW = 1;
    localparam int unsigned SW  = 6;
    localparam int unsigned IDX = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [SW-1:0] stall = '0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [FBW-1:0] in_fb = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [FBW-1:0] out_fb;
    logic          bubble_o;
`ifdef PIPE_STALL_CNT_EN
    logic [15:0]   hold_cnt;
    logic [15:0]   bubble_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W    (DW),
        .FB_W      (FBW),
        .STALL_W   (SW),
        .STAGE_IDX (IDX),
        .NOP_VALUE ({DW{1'b0}})
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_fb     (in_fb),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_fb    (out_fb),
        .bubble_o  (bubble_o)
`ifdef PIPE_STALL_CNT_EN
        ,
        .hold_cnt   (hold_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [FBW-1:0] m_fb;
    logic          m_bubble;
    int            m_hold;
    int            m_bub;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_data   = '0;
        m_fb     = '0;
        m_bubble = 1'b0;
        m_hold   = 0;
        m_bub    = 0;
    endtask

    task automatic model_edge();
        logic up;
        logic down;
        up   = stall[IDX];
        down = stall[IDX+1];
        if (flush) begin
            m_valid = 1'b0; m_data = '0; m_fb = '0; m_bubble = 1'b0;
        end else if (up && !down) begin
            m_valid = 1'b0; m_data = '0; m_bubble = 1'b1;
            if (m_bub < 65535) m_bub++;
        end else if (!up) begin
            m_valid = in_valid; m_data = in_data; m_fb = in_fb; m_bubble = 1'b0;
        end else begin
            if (m_hold < 65535) m_hold++;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check_eq({tag, ".data"}, out_data, m_data);
        check_eq({tag, ".fb"}, 32'(out_fb), 32'(m_fb));
        check_eq({tag, ".bubble"}, 32'(bubble_o), 32'(m_bubble));
`ifdef PIPE_STALL_CNT_EN
        check_eq({tag, ".hold_cnt"}, 32'(hold_cnt), 32'(m_hold));
        check_eq({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(m_bub));
`endif
    endtask

    task automatic step(input string tag, input logic [SW-1:0] s, input logic f,
                        input logic v, input logic [DW-1:0] d, input logic [FBW-1:0] fb);
        stall    = s;
        flush    = f;
        in_valid = v;
        in_data  = d;
        in_fb    = fb;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Legal controller patterns: a run of ones from the PC stage upward.
    function automatic logic [SW-1:0] rand_stall();
        logic [SW-1:0] s;
        int unsigned   len;
        s   = '0;
        len = $urandom_range(0, SW);
        for (int i = 0; i < int'(len); i++) s[i] = 1'b1;
        return s;
    endfunction

    initial begin
        model_reset();
        in_data = 32'hDEAD_BEEF;
        #3;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        step("load", 6'b000000, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
        check_eq("load.data_const", out_data, 32'h1234_5678);
        step("bubble", 6'b000111, 1'b0, 1'b1, 32'hCAFE_0001, 1'b0);
        check_eq("bubble.fb_held", 32'(out_fb), 32'd1);
        step("reload", 6'b000000, 1'b0, 1'b1, 32'hA5A5_5A5A, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step("hold", 6'b001111, 1'b0, 1'b0, 32'(i + 7), 1'b0);
        end
        check_eq("hold.data_frozen", out_data, 32'hA5A5_5A5A);
`ifdef PIPE_STALL_CNT_EN
        check_eq("hold.cnt3", 32'(hold_cnt), 32'd3);
`endif
        step("flush_hold", 6'b001111, 1'b1, 1'b1, 32'h0BAD_F00D, 1'b1);
        check_eq("flush.data_nop", out_data, 32'h0);
        step("after_flush", 6'b001111, 1'b0, 1'b1, 32'h1111_2222, 1'b1);
        step("invalid_load", 6'b000000, 1'b0, 1'b0, 32'h3333_4444, 1'b1);

        for (int i = 0; i < 400; i++) begin
            step("rand", rand_stall(), ($urandom_range(0, 7) == 0), 1'($urandom),
                 $urandom, FBW'($urandom));
        end

        step("pre_reset", 6'b000000, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        stall = 6'b001111;
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        check_eq("async_reset.data_nop", out_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step("post_reset", 6'b001111, 1'b0, 1'b1, 32'h5555_AAAA, 1'b1);
        step("post_reset_load", 6'b000011, 1'b0, 1'b1, 32'h5555_AAAA, 1'b1);

`ifdef PIPE_STALL_CNT_EN
        stall = 6'b001111;
        flush = 1'b0;
        repeat (70000) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        check_all("saturate");
        check_eq("saturate.hold_max", 32'(hold_cnt), 32'h0000_FFFF);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
